// File: rtl/line_clear_engine.sv
// Tetris line-clear stage: scans the captured board one row per cycle, removes full rows and settles the rest downward.
// Optional scoring is built only when LINE_CLEAR_SCORE_EN is defined.
module line_clear_engine #(
    parameter int ROWS = 20,
    parameter int COLS = 10,
    localparam int BITS = ROWS * COLS,
    localparam int RW   = $clog2(ROWS + 1)
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            start,
    input  logic [BITS-1:0] board_in,
    output logic [BITS-1:0] board_out,
    output logic            busy,
    output logic            done,
    output logic [RW-1:0]   lines_cleared,
    output logic [15:0]     score
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t          state;
    logic [BITS-1:0] work;
    logic [RW-1:0]   r;
    logic [RW-1:0]   count;

    logic            row_full;
    logic            last_row;
    logic            final_edge;
    logic [BITS-1:0] collapsed;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        row_full  = &work[int'(r)*COLS +: COLS];
        last_row  = (r == RW'(ROWS - 1));
        collapsed = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (i < int'(r)) begin
                collapsed[i*COLS +: COLS] = work[i*COLS +: COLS];
            end else if (i < ROWS - 1) begin
                collapsed[i*COLS +: COLS] = work[(i+1)*COLS +: COLS];
            end
        end
    end

    assign final_edge = (state == SCAN) && !row_full && last_row;

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    // NOTE: the work register is reset too, so an abandoned run leaves no stale board behind.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state         <= IDLE;
            work          <= '0;
            r             <= '0;
            count         <= '0;
            board_out     <= '0;
            lines_cleared <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        work  <= board_in;
                        r     <= '0;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (row_full) begin
                        // Same row is re-examined: the row above has just dropped into it.
                        work  <= collapsed;
                        count <= count + 1'b1;
                    end else if (!last_row) begin
                        r <= r + 1'b1;
                    end else begin
                        board_out     <= work;
                        lines_cleared <= count;
                        done          <= 1'b1;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LINE_CLEAR_SCORE_EN
    logic [3:0]  points;
    logic [16:0] score_sum;

    always_comb begin
        case (count)
            RW'(0):  points = 4'd0;
            RW'(1):  points = 4'd1;
            RW'(2):  points = 4'd3;
            RW'(3):  points = 4'd5;
            default: points = 4'd8;
        endcase
        score_sum = {1'b0, score} + {13'd0, points};
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            score <= '0;
        end else if (final_edge) begin
            score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
        end
    end
`else
    logic unused_final_edge;
    assign unused_final_edge = final_edge;
    assign score             = '0;
`endif

endmodule
